// File: rtl/edge_row_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edge_row_packer: packs the serial edge stream into row words, buffers     |
// | them in a small FIFO and keeps per-frame edge statistics.  Rev 1.0        |
// +--------------------------------------------------------------------------+
module edge_row_packer #(
  parameter int IMG_DIM    = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               edge_in,
  input  logic               edge_valid,
  output logic [IMG_DIM-1:0] row_data,
  output logic [4:0]         row_index,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               frame_done,
  output logic [8:0]         edge_count,
  output logic               overflow
);

  localparam int             PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [4:0]     LAST_POS = 5'(IMG_DIM - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE  = (PTR_W + 1)'(1);

  logic [4:0]         col_q, col_d;
  logic [4:0]         row_q, row_d;
  logic [IMG_DIM-1:0] asm_q, asm_d;
  logic [8:0]         acc_q, acc_d;
  logic [8:0]         edge_count_q, edge_count_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [IMG_DIM-1:0] data_mem_q [FIFO_DEPTH];
  logic [IMG_DIM-1:0] data_mem_d [FIFO_DEPTH];
  logic [4:0]         idx_mem_q  [FIFO_DEPTH];
  logic [4:0]         idx_mem_d  [FIFO_DEPTH];

  logic [IMG_DIM-1:0] row_word;
  logic [PTR_W:0]     fill;
  logic               fifo_empty;
  logic               fifo_full;
  logic               row_end;
  logic               frame_end;
  logic               do_pop;
  logic               do_push;

  always_comb begin
    row_word          = asm_q;
    row_word[col_q]   = edge_in;
    fill              = wr_ptr_q - rd_ptr_q;
    fifo_empty        = (fill == '0);
    fifo_full         = (fill == FULL_CNT);
    row_end           = edge_valid && (col_q == LAST_POS);
    frame_end         = row_end && (row_q == LAST_POS);
    do_pop            = !fifo_empty && row_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    do_push           = row_end && (!fifo_full || do_pop);
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    asm_d        = asm_q;
    acc_d        = acc_q;
    edge_count_d = edge_count_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_mem_d   = data_mem_q;
    idx_mem_d    = idx_mem_q;

    if (edge_valid) begin
      acc_d = acc_q + {8'd0, edge_in};
      if (row_end) begin
        col_d = '0;
        asm_d = '0;
        row_d = (row_q == LAST_POS) ? 5'd0 : row_q + 5'd1;
        if (frame_end) begin
          edge_count_d = acc_d;
          acc_d        = '0;
          frame_done_d = 1'b1;
        end
      end else begin
        col_d = col_q + 5'd1;
        asm_d = row_word;
      end
    end

    if (do_push) begin
      data_mem_d[wr_ptr_q[PTR_W-1:0]] = row_word;
      idx_mem_d[wr_ptr_q[PTR_W-1:0]]  = row_q;
      wr_ptr_d                        = wr_ptr_q + PTR_ONE;
    end else if (row_end) begin
      overflow_d = 1'b1;
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      asm_q        <= '0;
      acc_q        <= '0;
      edge_count_q <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      asm_q        <= asm_d;
      acc_q        <= acc_d;
      edge_count_q <= edge_count_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    data_mem_q <= data_mem_d;
    idx_mem_q  <= idx_mem_d;
  end

  assign row_valid  = !fifo_empty;
  assign row_data   = fifo_empty ? '0 : data_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign row_index  = fifo_empty ? '0 : idx_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign frame_done = frame_done_q;
  assign edge_count = edge_count_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_row_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_edge_row_packer: directed and random stimulus against a queue-based    |
// | reference model of the row packer.  Rev 1.0                               |
// +--------------------------------------------------------------------------+
module tb_edge_row_packer;

  localparam int IMG_DIM    = 20;
  localparam int FIFO_DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               edge_in;
  logic               edge_valid;
  logic [IMG_DIM-1:0] row_data;
  logic [4:0]         row_index;
  logic               row_valid;
  logic               row_ready;
  logic               frame_done;
  logic [8:0]         edge_count;
  logic               overflow;

  edge_row_packer #(.IMG_DIM(IMG_DIM), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .edge_in    (edge_in),
    .edge_valid (edge_valid),
    .row_data   (row_data),
    .row_index  (row_index),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .frame_done (frame_done),
    .edge_count (edge_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IMG_DIM-1:0] data;
    logic [4:0]         idx;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  ent_t mq[$];
  bit   row_bits[$];
  int   m_row;
  int   m_acc;
  int   m_ec;
  bit   m_ovf;
  bit   m_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    row_bits.delete();
    m_row = 0;
    m_acc = 0;
    m_ec  = 0;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
  endtask

  task automatic compare_model();
    ent_t head;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk("row_valid",  {31'd0, row_valid}, {31'd0, mq.size() != 0});
    chk("row_data",   {12'd0, row_data},  {12'd0, head.data});
    chk("row_index",  {27'd0, row_index}, {27'd0, head.idx});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    chk("edge_count", {23'd0, edge_count}, m_ec);
    chk("overflow",   {31'd0, overflow},  {31'd0, m_ovf});
  endtask

  // One clock: drive inputs, advance the model by the edge's rules, compare.
  task automatic step(input bit v, input bit b, input bit rdy);
    bit   was_full;
    bit   popped;
    ent_t e;
    edge_valid = v;
    edge_in    = b;
    row_ready  = rdy;
    @(posedge clk);
    was_full = (mq.size() == FIFO_DEPTH);
    popped   = (mq.size() != 0) && rdy;
    m_fd     = 1'b0;
    if (popped) void'(mq.pop_front());
    if (v) begin
      row_bits.push_back(b);
      m_acc += int'(b);
      if (row_bits.size() == IMG_DIM) begin
        e.data = '0;
        for (int k = 0; k < IMG_DIM; k++) e.data = e.data | (IMG_DIM'(row_bits[k]) << k);
        e.idx = 5'(m_row);
        if (was_full && !popped) m_ovf = 1'b1;
        else mq.push_back(e);
        if (m_row == IMG_DIM - 1) begin
          m_ec  = m_acc;
          m_acc = 0;
          m_fd  = 1'b1;
        end
        m_row = (m_row + 1) % IMG_DIM;
        row_bits.delete();
      end
    end
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    edge_valid = 1'b0;
    edge_in    = 1'b0;
    row_ready  = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_row_valid",  {31'd0, row_valid}, 0);
    chk("rst_row_data",   {12'd0, row_data}, 0);
    chk("rst_row_index",  {27'd0, row_index}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_edge_count", {23'd0, edge_count}, 0);
    chk("rst_overflow",   {31'd0, overflow}, 0);
    reset = 1'b0;
  endtask

  initial begin
    int   words;
    int   fd_seen;
    int   pops;
    bit   f1 [400];
    bit   tmp;
    int   j;
    logic [IMG_DIM-1:0] exp_word;
    logic [IMG_DIM-1:0] one_bit;

    reset      = 1'b1;
    edge_valid = 1'b0;
    edge_in    = 1'b0;
    row_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single row 1,0,...,0,1
    do_reset();
    for (int k = 0; k < IMG_DIM; k++) step(1'b1, (k == 0) || (k == IMG_DIM - 1), 1'b0);
    chk("single_valid", {31'd0, row_valid}, 1);
    chk("single_data",  {12'd0, row_data}, 32'h80001);
    chk("single_index", {27'd0, row_index}, 0);
    step(1'b0, 1'b0, 1'b1);
    chk("single_pop_valid", {31'd0, row_valid}, 0);
    chk("single_pop_data",  {12'd0, row_data}, 0);

    // Full frame of ones with edge_valid toggling
    do_reset();
    words   = 0;
    fd_seen = 0;
    for (int i = 0; i < 2 * IMG_DIM * IMG_DIM + 2; i++) begin
      step((i % 2) == 0 && i < 2 * IMG_DIM * IMG_DIM, 1'b1, 1'b1);
      fd_seen += int'(frame_done);
      if (row_valid) begin
        chk("gap_word",  {12'd0, row_data}, 32'hFFFFF);
        chk("gap_index", {27'd0, row_index}, words);
        words++;
      end
    end
    chk("gap_words",      words, 20);
    chk("gap_frame_done", fd_seen, 1);
    chk("gap_edge_count", {23'd0, edge_count}, 400);

    // Overflow: five rows with no consumer
    do_reset();
    for (int i = 0; i < 5 * IMG_DIM; i++) step(1'b1, 1'($urandom), 1'b0);
    chk("ovf_set", {31'd0, overflow}, 1);
    pops = 0;
    for (int i = 0; i < 10 && row_valid; i++) begin
      chk("ovf_drain_index", {27'd0, row_index}, pops);
      step(1'b0, 1'b0, 1'b1);
      pops++;
    end
    chk("ovf_pops",   pops, 4);
    chk("ovf_sticky", {31'd0, overflow}, 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 5 * IMG_DIM; i++) step(1'b1, 1'($urandom), i == 5 * IMG_DIM - 1);
    chk("pp_overflow", {31'd0, overflow}, 0);
    pops = 0;
    for (int i = 0; i < 10 && row_valid; i++) begin
      chk("pp_drain_index", {27'd0, row_index}, pops + 1);
      step(1'b0, 1'b0, 1'b1);
      pops++;
    end
    chk("pp_pops", pops, 4);

    // Back-to-back frames: 37 ones, then all zeros
    do_reset();
    for (int i = 0; i < 400; i++) f1[i] = (i < 37);
    for (int i = 399; i > 0; i--) begin
      j     = int'($urandom_range(i, 0));
      tmp   = f1[i];
      f1[i] = f1[j];
      f1[j] = tmp;
    end
    for (int i = 0; i < 400; i++) step(1'b1, f1[i], 1'b1);
    chk("b2b_fd1", {31'd0, frame_done}, 1);
    chk("b2b_ec1", {23'd0, edge_count}, 37);
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == IMG_DIM - 1) begin
        chk("b2b_f2_valid", {31'd0, row_valid}, 1);
        chk("b2b_f2_index", {27'd0, row_index}, 0);
      end
    end
    chk("b2b_fd2", {31'd0, frame_done}, 1);
    chk("b2b_ec2", {23'd0, edge_count}, 0);

    // Reset in the middle of a row with two rows queued
    do_reset();
    for (int i = 0; i < 210; i++) step(1'b1, 1'($urandom), i < 170);
    chk("mid_queued", {31'd0, row_valid}, 1);
    do_reset();
    exp_word = '0;
    for (int i = 0; i < IMG_DIM; i++) begin
      tmp      = 1'($urandom);
      one_bit  = IMG_DIM'(tmp);
      exp_word = exp_word | (one_bit << i);
      step(1'b1, tmp, 1'b0);
    end
    chk("mid_after_index", {27'd0, row_index}, 0);
    chk("mid_after_data",  {12'd0, row_data}, {12'd0, exp_word});

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(9, 0) < 7, 1'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
